// File: rtl/blake_round_seq.sv
// blake_round_seq: round/step sequencer for an iterated BLAKE-256/512 compression core.
//
// One compression runs IDLE -> INIT -> ROUND x (N*STEPS) -> FINAL -> DONE -> IDLE.
// N is 14 rounds for BLAKE-256 (mode=0) and 16 for BLAKE-512 (mode=1). The mode is
// captured when start is accepted. Every output comes straight from a flop.
//
// Parameters
//   STEPS     G-steps per round (8 / G-cores instantiated): 1, 2, 4 or 8
//   STEP_W    width of step_idx, >= 1 and >= clog2(STEPS)
//
// Ports
//   clk        clock
//   rstb       asynchronous active-low reset
//   start      begin one compression (sampled only in IDLE)
//   mode       1 = BLAKE-512 (16 rounds), 0 = BLAKE-256 (14 rounds)
//   done_ack   consumer has taken the result (sampled only in DONE)
//   abort      (only with BLAKE_SEQ_ABORT_EN) drop the compression from INIT/ROUND/FINAL
//   init_round load state matrix from chaining value, salt and counter
//   round_ing  G-function datapath enable
//   round_idx  current round, 0 .. N-1
//   sigma_sel  message permutation select, round_idx mod 10
//   step_idx   current step within the round
//   finalize   fold state into the chaining value
//   done       result valid, held until done_ack
//   busy       high in every state except IDLE
//
// Compile-time option: define BLAKE_SEQ_ABORT_EN to add the abort input.

module blake_round_seq #(
    parameter int unsigned STEPS  = 4,
    parameter int unsigned STEP_W = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              mode,
    input  logic              done_ack,
`ifdef BLAKE_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              init_round,
    output logic              round_ing,
    output logic [4:0]        round_idx,
    output logic [3:0]        sigma_sel,
    output logic [STEP_W-1:0] step_idx,
    output logic              finalize,
    output logic              done,
    output logic              busy
);

    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StInit  = 5'b00010,
        StRound = 5'b00100,
        StFinal = 5'b01000,
        StDone  = 5'b10000
    } state_e;

    localparam logic [STEP_W-1:0] StepLast = STEP_W'(STEPS - 1);

    state_e            state_q, state_d;
    logic              mode_q;
    logic [4:0]        round_q;
    logic [3:0]        sigma_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;
    logic [4:0]        round_last;
    logic              round_end;

    assign round_last = mode_q ? 5'd15 : 5'd13;
    assign round_end  = (round_q == round_last) && (step_q == StepLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StInit;
            StInit:  state_d = StRound;
            StRound: if (round_end) state_d = StFinal;
            StFinal: state_d = StDone;
            // A start in the ack cycle is not seen: IDLE only samples start next cycle.
            StDone:  if (done_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef BLAKE_SEQ_ABORT_EN
        if (abort && ((state_q == StInit) || (state_q == StRound) || (state_q == StFinal))) begin
            state_d = StIdle;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            round_q <= 5'd0;
            sigma_q <= 4'd0;
            step_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            if ((state_q == StIdle) && (state_d == StInit)) begin
                mode_q  <= mode;
                round_q <= 5'd0;
                sigma_q <= 4'd0;
                step_q  <= '0;
            end else if ((state_q == StRound) && (state_d == StRound)) begin
                // Counters only move while staying in ROUND, so they freeze on the last
                // step (and on abort) and hold through FINAL, DONE and IDLE.
                if (step_q == StepLast) begin
                    step_q  <= '0;
                    round_q <= round_q + 5'd1;
                    sigma_q <= (sigma_q == 4'd9) ? 4'd0 : sigma_q + 4'd1;
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    // One-hot state bits double as the registered strobes.
    assign init_round = state_q[1];
    assign round_ing  = state_q[2];
    assign finalize   = state_q[3];
    assign done       = state_q[4];
    assign busy       = busy_q;
    assign round_idx  = round_q;
    assign sigma_sel  = sigma_q;
    assign step_idx   = step_q;

endmodule

// File: tb/tb_blake_round_seq.sv
// tb_blake_round_seq: scoreboard bench for blake_round_seq.
//
// Three instances (STEPS = 4, 1, 8) share clock and reset. Each accepted start pushes
// the expected timeline of that compression into a queue; a monitor following the
// selected instance builds the observed timeline and checks it when done rises.
// With BLAKE_SEQ_ABORT_EN defined the abort input is connected and exercised.

module tb_blake_round_seq;

    typedef struct {
        int dut;
        int s_cyc;
        int ncyc;
        int last_r;
        int last_s;
        int nsig;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstb;
    logic [2:0]      start_v, mode_v, ack_v, abort_v;
    logic [2:0]      init_v, ring_v, fin_v, done_v, busy_v;
    logic [2:0][4:0] ridx_v;
    logic [2:0][3:0] sig_v;
    logic [2:0][2:0] sidx_v;
    logic [1:0]      st4;
    logic [0:0]      st1;
    logic [2:0]      st8;
    logic            any_out;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   sel = 0;
    exp_t exp_q[$];
    int   sig_exp [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sidx_v[0] = 3'(st4);
    assign sidx_v[1] = 3'(st1);
    assign sidx_v[2] = 3'(st8);
    assign any_out   = |{init_v, ring_v, fin_v, done_v, busy_v, ridx_v, sig_v, sidx_v};

    blake_round_seq #(.STEPS(4), .STEP_W(2)) u_s4 (
        .clk(clk), .rstb(rstb), .start(start_v[0]), .mode(mode_v[0]), .done_ack(ack_v[0]),
`ifdef BLAKE_SEQ_ABORT_EN
        .abort(abort_v[0]),
`endif
        .init_round(init_v[0]), .round_ing(ring_v[0]), .round_idx(ridx_v[0]),
        .sigma_sel(sig_v[0]), .step_idx(st4), .finalize(fin_v[0]), .done(done_v[0]),
        .busy(busy_v[0])
    );

    blake_round_seq #(.STEPS(1), .STEP_W(1)) u_s1 (
        .clk(clk), .rstb(rstb), .start(start_v[1]), .mode(mode_v[1]), .done_ack(ack_v[1]),
`ifdef BLAKE_SEQ_ABORT_EN
        .abort(abort_v[1]),
`endif
        .init_round(init_v[1]), .round_ing(ring_v[1]), .round_idx(ridx_v[1]),
        .sigma_sel(sig_v[1]), .step_idx(st1), .finalize(fin_v[1]), .done(done_v[1]),
        .busy(busy_v[1])
    );

    blake_round_seq #(.STEPS(8), .STEP_W(3)) u_s8 (
        .clk(clk), .rstb(rstb), .start(start_v[2]), .mode(mode_v[2]), .done_ack(ack_v[2]),
`ifdef BLAKE_SEQ_ABORT_EN
        .abort(abort_v[2]),
`endif
        .init_round(init_v[2]), .round_ing(ring_v[2]), .round_idx(ridx_v[2]),
        .sigma_sel(sig_v[2]), .step_idx(st8), .finalize(fin_v[2]), .done(done_v[2]),
        .busy(busy_v[2])
    );

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: follows instance 'sel', samples on the falling edge.
    logic       m_init, m_ring, m_fin, m_done, m_busy;
    logic [4:0] m_ridx;
    logic [3:0] m_sig;
    logic [2:0] m_sidx;
    always_comb begin
        m_init = init_v[sel];
        m_ring = ring_v[sel];
        m_fin  = fin_v[sel];
        m_done = done_v[sel];
        m_busy = busy_v[sel];
        m_ridx = ridx_v[sel];
        m_sig  = sig_v[sel];
        m_sidx = sidx_v[sel];
    end

    int   o_init, o_first, o_last, o_cnt, o_fin, o_lr, o_ls;
    int   o_sig [16];
    logic prev_ring = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (!rstb) begin
            o_init = -1; o_first = -1; o_last = -1; o_fin = -1; o_cnt = 0;
            prev_ring = 1'b0;
            prev_done = 1'b0;
        end else begin
            chk("strobe_exclusive",
                ($countones({m_init, m_ring, m_fin, m_done}) <= 1 &&
                 m_busy == (m_init | m_ring | m_fin | m_done)) ? 1 : 0, 1);
            if (m_init) begin
                o_init = cyc; o_first = -1; o_last = -1; o_fin = -1; o_cnt = 0;
                for (int i = 0; i < 16; i++) o_sig[i] = -1;
            end
            if (m_ring) begin
                if (!prev_ring) o_first = cyc;
                o_cnt++;
                o_last = cyc;
                o_lr = int'(m_ridx);
                o_ls = int'(m_sidx);
                if (m_sidx == 3'd0 && m_ridx < 5'd16) o_sig[m_ridx[3:0]] = int'(m_sig);
            end
            if (m_fin) o_fin = cyc;
            if (m_done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dut_sel", sel, e.dut);
                    chk("init_cycle", o_init - e.s_cyc, 1);
                    chk("first_round_cycle", o_first - e.s_cyc, 2);
                    chk("round_count", o_cnt, e.ncyc);
                    chk("last_round_cycle", o_last - e.s_cyc, 1 + e.ncyc);
                    chk("final_cycle", o_fin - e.s_cyc, 2 + e.ncyc);
                    chk("done_cycle", cyc - e.s_cyc, 3 + e.ncyc);
                    chk("last_round_idx", o_lr, e.last_r);
                    chk("last_step_idx", o_ls, e.last_s);
                    chk("round_idx_held", int'(m_ridx), e.last_r);
                    bad = 0;
                    for (int i = 0; i < e.nsig; i++) if (o_sig[i] != sig_exp[i]) bad++;
                    chk("sigma_seq_errors", bad, 0);
                end
            end
            prev_ring = m_ring;
            prev_done = m_done;
        end
    end

    task automatic push_exp(input int idx, input int ncyc, input int lr, input int ls,
                            input int nsig);
        exp_t e;
        e.dut = idx; e.s_cyc = cyc; e.ncyc = ncyc; e.last_r = lr; e.last_s = ls; e.nsig = nsig;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; start is sampled on the following rising edge.
    task automatic issue(input int idx, input logic m, input int ncyc, input int lr,
                         input int ls, input int nsig);
        start_v[idx] = 1'b1;
        mode_v[idx]  = m;
        push_exp(idx, ncyc, lr, ls, nsig);
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int n = 0;
        while (!done_v[idx] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[idx]) chk("done_timeout", 0, 1);
    endtask

    task automatic ack(input int idx);
        ack_v[idx] = 1'b1;
        @(negedge clk);
        ack_v[idx] = 1'b0;
        chk("ack_back_to_idle", int'({busy_v[idx], done_v[idx]}), 0);
    endtask

    initial begin
        int held;
        int bad;
        rstb = 1'b0;
        start_v = '0; mode_v = '0; ack_v = '0; abort_v = '0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(any_out), 0);
        #1 rstb = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", int'(any_out), 0);

        // STEPS=4, BLAKE-512: 64 round cycles, ends at round 15 step 3.
        sel = 0;
        issue(0, 1'b1, 64, 15, 3, 16);
        wait_done(0);
        held = 0;
        repeat (10) begin
            if (done_v[0] && busy_v[0]) held++;
            @(negedge clk);
        end
        chk("done_held_cycles", held, 10);

        // Ack with start in the same cycle: start must be dropped.
        ack_v[0] = 1'b1; start_v[0] = 1'b1; mode_v[0] = 1'b0;
        @(negedge clk);
        ack_v[0] = 1'b0;
        chk("ack_start_busy", int'(busy_v[0]), 0);
        chk("ack_start_init", int'(init_v[0]), 0);
        chk("ack_start_done", int'(done_v[0]), 0);
        // start still high this cycle, now in IDLE: accepted, BLAKE-256.
        push_exp(0, 56, 13, 3, 14);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (30) begin
            mode_v[0] = ~mode_v[0];
            @(negedge clk);
        end
        mode_v[0] = 1'b1;
        wait_done(0);
        ack(0);

        // Reset at ROUND cycle 20 (round 5, step 0).
        start_v[0] = 1'b1; mode_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("round_start_ring", int'(ring_v[0]), 1);
        repeat (20) @(negedge clk);
        chk("round20_round_idx", int'(ridx_v[0]), 5);
        chk("round20_step_idx", int'(sidx_v[0]), 0);
        #1 rstb = 1'b0;
        #1 chk("async_reset_outputs", int'(any_out), 0);
        @(negedge clk);
        #1 rstb = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (any_out) bad++;
        end
        chk("quiet_after_reset_cycles", bad, 0);
        issue(0, 1'b1, 64, 15, 3, 16);
        wait_done(0);
        ack(0);

        // STEPS=1 and STEPS=8, BLAKE-512.
        sel = 1;
        issue(1, 1'b1, 16, 15, 0, 16);
        wait_done(1);
        ack(1);
        sel = 2;
        issue(2, 1'b1, 128, 15, 7, 16);
        wait_done(2);
        ack(2);

`ifdef BLAKE_SEQ_ABORT_EN
        // Abort at ROUND cycle 5 (round 1, step 1): counters freeze there.
        sel = 0;
        start_v[0] = 1'b1; mode_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_ring", int'(ring_v[0]), 0);
        chk("abort_round_idx", int'(ridx_v[0]), 1);
        chk("abort_step_idx", int'(sidx_v[0]), 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) bad++;
        end
        chk("abort_no_done_cycles", bad, 0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blake_round_seq.md
BLAKE_ROUND_SEQ -- requirements
Module: blake_round_seq

Interface
REQ-001 The block SHALL have parameter STEPS, default 4, meaning G-steps per round (8 / G-cores instantiated); legal values 1, 2, 4, 8.
REQ-002 The block SHALL have parameter STEP_W, default 2, meaning the width of step_idx; it SHALL be at least 1 and at least clog2(STEPS).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rstb, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin one compression.
REQ-006 The block SHALL have port mode, input, 1 bit: 1 = BLAKE-512 (16 rounds), 0 = BLAKE-256 (14 rounds).
REQ-007 The block SHALL have port done_ack, input, 1 bit: the consumer has taken the result.
REQ-008 The block SHALL have port init_round, output, 1 bit: load the state matrix from chaining value, salt and counter.
REQ-009 The block SHALL have port round_ing, output, 1 bit: G-function datapath enable.
REQ-010 The block SHALL have port round_idx, output, 5 bits: current round, 0 to N-1.
REQ-011 The block SHALL have port sigma_sel, output, 4 bits: permutation select, equal to round_idx mod 10.
REQ-012 The block SHALL have port step_idx, output, STEP_W bits: current step within the round.
REQ-013 The block SHALL have port finalize, output, 1 bit: fold the state into the chaining value.
REQ-014 The block SHALL have port done, output, 1 bit: result valid; held until acknowledged.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The state machine SHALL have exactly five states: IDLE, INIT, ROUND, FINAL, DONE, one-hot encoded.
REQ-017 In IDLE, start=1 SHALL cause a transition to INIT on the next edge, and mode SHALL be latched into an internal register on that same edge.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 Changes on mode after it is latched SHALL have no effect until the next accepted start.
REQ-020 INIT SHALL last exactly 1 cycle with init_round=1, and SHALL then go to ROUND.
REQ-021 In ROUND, round_ing SHALL be 1.
REQ-022 In ROUND, step_idx SHALL increment every cycle and wrap from STEPS-1 to 0.
REQ-023 In ROUND, round_idx SHALL increment when step_idx wraps.
REQ-024 ROUND SHALL last exactly N*STEPS cycles, where N = 16 if the latched mode is 1 and N = 14 otherwise.
REQ-025 ROUND SHALL exit to FINAL on the cycle where round_idx = N-1 and step_idx = STEPS-1.
REQ-026 When STEPS=1, step_idx SHALL stay at 0 and round_idx SHALL increment every cycle.
REQ-027 FINAL SHALL last 1 cycle with finalize=1, and SHALL then go to DONE.
REQ-028 DONE SHALL hold done=1 until done_ack=1, and SHALL return to IDLE on the edge where done_ack=1.
REQ-029 A start asserted in the same cycle as done_ack SHALL NOT be accepted.
REQ-030 done_ack outside DONE SHALL be ignored.
REQ-031 round_idx and step_idx SHALL be cleared to 0 on entry to INIT and SHALL hold their values in FINAL, DONE and IDLE.
REQ-032 init_round, round_ing and finalize SHALL be mutually exclusive.
REQ-033 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-034 sigma_sel SHALL wrap from 9 to 0, so that rounds 10 to 15 use sigma_sel 0 to 5.

Reset
REQ-035 While rstb=0, the state SHALL be IDLE, all counters and the latched mode SHALL be 0, and every output SHALL be 0, independent of clk.
REQ-036 Assertion of rstb in any state, including mid-ROUND, SHALL abandon the compression.
REQ-037 After rstb deasserts, no output SHALL assert before a new start is accepted.

Configuration
REQ-038 The block SHALL support the compile-time macro BLAKE_SEQ_ABORT_EN.
REQ-039 When BLAKE_SEQ_ABORT_EN is defined, the block SHALL add input abort (1 bit).
REQ-040 When BLAKE_SEQ_ABORT_EN is defined, abort=1 in INIT, ROUND or FINAL SHALL force IDLE on the next edge with done never asserted, and counters SHALL hold their values.
REQ-041 When BLAKE_SEQ_ABORT_EN is defined, abort SHALL have priority over all other transitions and SHALL be ignored in IDLE and DONE.
REQ-042 When BLAKE_SEQ_ABORT_EN is not defined, the abort port SHALL be absent and behaviour SHALL be exactly as in REQ-016 to REQ-034.

Verification
REQ-043 The bench SHALL cover: STEPS=4, mode=1, start pulsed at cycle 0 -> init_round at cycle 1; round_ing for cycles 2-65 (64 cycles); round_idx 15 and step_idx 3 at cycle 65; finalize at cycle 66; done from cycle 67.
REQ-044 The bench SHALL cover: STEPS=4, mode=0 -> round_ing for exactly 56 cycles and last round_idx = 13; mode toggled during ROUND -> count unchanged.
REQ-045 The bench SHALL cover: done held high for 10 cycles with done_ack=0, then done_ack=1 together with start=1 -> IDLE and busy=0; start stays ignored until the following cycle.
REQ-046 The bench SHALL cover: rstb pulsed low at ROUND cycle 20 -> all outputs 0 immediately, no done afterwards; a fresh start -> the full 64-cycle sequence.
REQ-047 The bench SHALL cover: STEPS=1 and STEPS=8 with mode=1 -> 16 and 128 round_ing cycles respectively; sigma_sel sequence 0..9,0..5.
REQ-048 The bench SHALL cover, with BLAKE_SEQ_ABORT_EN defined: abort=1 at ROUND cycle 5 -> IDLE next edge, done stays 0, busy=0.
